sram_responder: RTL and testbench
=================================

Name: sram_responder

Overview:
- Memory-side responder for the core's instruction/data fetch interface; answers IFU/LSU-style requests over a valid/ready request channel and a valid/ready response channel.
- Holds a word-organised SRAM array with byte-masked writes and a programmable access latency.
- One outstanding transaction at a time.
- Replaces the zero-latency combinational memory model so the core's multi-cycle controller can be exercised against real handshakes.

Parameters:
- DEPTH_LOG2, 10: array holds 2^DEPTH_LOG2 32-bit words.
- BASE_ADDR, 32'h8000_0000: byte address of word 0.
- LATENCY, 1: extra wait cycles between request accept and array access (0..15).

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  reset, asynchronous, active-low
- req_valid  in  1  initiator presents a request
- req_ready  out  1  responder can accept a request
- req_addr  in  32  byte address; bits [1:0] ignored
- req_wen  in  1  1 = write, 0 = read
- req_wdata  in  32  write data, lane-aligned
- req_wmask  in  4  byte enables for writes; bit i covers wdata[8i+7:8i]
- resp_valid  out  1  response available
- resp_ready  in  1  initiator accepts the response
- resp_rdata  out  32  read data; 0 for writes and errors
- resp_err  out  1  address out of range

Behaviour:
- Reset (rst=0, async):
  - state=IDLE, resp_valid=0, resp_rdata=0, resp_err=0, wait counter=0.
  - Array contents are not reset.
  - Any captured request is discarded; a write not yet performed is never performed.
- States: IDLE, WAIT, RESP.
- req_ready = (state==IDLE), combinational. It is 1 during and immediately after reset.
- IDLE:
  - On req_valid && req_ready: capture addr/wen/wdata/wmask.
  - If LATENCY==0, go to RESP, performing the access on the same edge.
  - Otherwise load cnt=LATENCY-1 and go to WAIT.
- WAIT:
  - req_ready=0.
  - If cnt!=0, decrement.
  - If cnt==0, perform the access and go to RESP.
- Access:
  - in-range iff BASE_ADDR <= addr < BASE_ADDR + 4*2^DEPTH_LOG2, compared as unsigned 32-bit with no wrap.
  - index = (addr-BASE_ADDR)[DEPTH_LOG2+1:2].
  - Read: resp_rdata <= mem[index].
  - Write: for each set wmask bit, update that byte lane only; resp_rdata <= 0.
  - wmask=0 with wen=1 is a legal no-op write that still responds.
  - Out of range: no array update, resp_rdata <= 0, resp_err <= 1; otherwise resp_err <= 0.
- RESP:
  - resp_valid=1; resp_rdata and resp_err held stable until resp_ready.
  - On resp_valid && resp_ready, go to IDLE and drop resp_valid on that edge.
  - A new request can be accepted no earlier than the following cycle.
- Latency: with resp_ready held high, resp_valid rises LATENCY+1 cycles after the accept edge and stays high for exactly one cycle.
- Request inputs are ignored outside IDLE. The initiator must hold req_* stable while req_valid=1 and req_ready=0.
- Read-after-write to the same word in back-to-back transactions returns the new data, because the write completes before its response.

Optional Feature:
- Macro: SRAM_RESPONDER_RANDOM_DELAY_EN.
- When defined:
  - An 8-bit Fibonacci LFSR (taps 8,6,5,4) is seeded to 8'hA5 on reset and advances every cycle.
  - On accept, the total wait becomes LATENCY + lfsr[2:0]. If that total is 0, go straight to RESP; otherwise load cnt = total-1 and enter WAIT.
  - The delay is therefore LATENCY+1 .. LATENCY+8 cycles, deterministic from reset.
- When undefined: the LFSR is absent and latency is fixed at LATENCY+1.

Test Plan:
- Write then read: LATENCY=1. Write addr 8000_0010, wdata DEADBEEF, wmask F; then read addr 8000_0010 -> write response rdata=0, err=0, resp_valid 2 cycles after accept; read returns DEADBEEF.
- Byte mask: word 8000_0010 holds DEADBEEF; write wdata 0000_5500, wmask 0010 -> read returns DEAD55EF.
- Out of range: read 7FFF_FFFC and write 8000_1000 (DEPTH_LOG2=10) -> err=1, rdata=0; the write leaves word 0 unchanged.
- Backpressure: hold resp_ready=0 for 5 cycles in RESP -> resp_valid, rdata and err stable; req_ready=0 throughout; a req_valid pulse meanwhile is ignored; release -> back to IDLE and req_ready=1 next cycle.
- Reset mid-WAIT: LATENCY=4, write 8000_0000 data 12345678, assert rst during WAIT -> outputs clear immediately; a later read of 8000_0000 shows the old value.
- LATENCY=0, read with resp_ready high -> resp_valid exactly 1 cycle after accept. Back-to-back requests -> accepts are spaced 2 cycles apart.

Source files
------------

// File: rtl/sram_responder.sv
// Word-organised SRAM responder with valid/ready request and response channels.
// Optional pseudo-random extra access delay: define SRAM_RESPONDER_RANDOM_DELAY_EN.
module sram_responder #(
    parameter int unsigned DEPTH_LOG2 = 10,
    parameter logic [31:0] BASE_ADDR  = 32'h8000_0000,
    parameter int unsigned LATENCY    = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [31:0] req_addr,
    input  logic        req_wen,
    input  logic [31:0] req_wdata,
    input  logic [3:0]  req_wmask,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata,
    output logic        resp_err
);

    localparam int unsigned DEPTH = 1 << DEPTH_LOG2;
    localparam logic [32:0] LIMIT = {1'b0, BASE_ADDR} + (33'd4 << DEPTH_LOG2);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_RESP
    } state_t;

    state_t r_state;
    state_t w_state_nxt;
    logic [4:0] r_cnt;
    logic [4:0] w_cnt_nxt;
    logic [4:0] w_total;
    logic w_accept;
    logic w_access;

    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic        r_wen;
    logic [3:0]  r_wmask;

    logic [31:0] w_acc_addr;
    logic [31:0] w_acc_wdata;
    logic        w_acc_wen;
    logic [3:0]  w_acc_wmask;
    logic        w_in_range;
    logic [31:0] w_offset;
    logic [DEPTH_LOG2-1:0] w_idx;
    logic        w_mem_we;

    logic [31:0] r_mem [DEPTH];

`ifdef SRAM_RESPONDER_RANDOM_DELAY_EN
    logic [7:0] r_lfsr;

    // Fibonacci LFSR, taps 8,6,5,4; free-running so the delay sequence depends only on time since reset
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_lfsr <= 8'hA5;
        end else begin
            r_lfsr <= {r_lfsr[6:0], r_lfsr[7] ^ r_lfsr[5] ^ r_lfsr[4] ^ r_lfsr[3]};
        end
    end

    assign w_total = 5'(LATENCY) + 5'(r_lfsr[2:0]);
`else
    assign w_total = 5'(LATENCY);
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_accept    = 1'b0;
        w_access    = 1'b0;
        req_ready   = 1'b0;
        resp_valid  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    w_accept = 1'b1;
                    if (w_total == '0) begin
                        w_access    = 1'b1;
                        w_state_nxt = ST_RESP;
                    end else begin
                        w_cnt_nxt   = w_total - 5'd1;
                        w_state_nxt = ST_WAIT;
                    end
                end
            end
            ST_WAIT: begin
                if (r_cnt != '0) begin
                    w_cnt_nxt = r_cnt - 5'd1;
                end else begin
                    w_access    = 1'b1;
                    w_state_nxt = ST_RESP;
                end
            end
            ST_RESP: begin
                resp_valid = 1'b1;
                if (resp_ready) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_addr  <= '0;
            r_wdata <= '0;
            r_wen   <= 1'b0;
            r_wmask <= '0;
        end else if (w_accept) begin
            r_addr  <= req_addr;
            r_wdata <= req_wdata;
            r_wen   <= req_wen;
            r_wmask <= req_wmask;
        end
    end

    // Zero-wait accesses come straight from the request bus; otherwise from the captured copy
    always_comb begin
        if (r_state == ST_IDLE) begin
            w_acc_addr  = req_addr;
            w_acc_wdata = req_wdata;
            w_acc_wen   = req_wen;
            w_acc_wmask = req_wmask;
        end else begin
            w_acc_addr  = r_addr;
            w_acc_wdata = r_wdata;
            w_acc_wen   = r_wen;
            w_acc_wmask = r_wmask;
        end
    end

    assign w_in_range = ({1'b0, w_acc_addr} >= {1'b0, BASE_ADDR}) && ({1'b0, w_acc_addr} < LIMIT);
    assign w_offset   = w_acc_addr - BASE_ADDR;
    assign w_idx      = DEPTH_LOG2'(w_offset >> 2);
    // Gated by rst so a request presented while reset is held can never reach the array
    assign w_mem_we   = rst && w_access && w_acc_wen && w_in_range;

    always_ff @(posedge clk) begin
        if (w_mem_we) begin
            for (int unsigned i = 0; i < 4; i++) begin
                if (w_acc_wmask[i]) begin
                    r_mem[w_idx][8*i +: 8] <= w_acc_wdata[8*i +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            resp_rdata <= '0;
            resp_err   <= 1'b0;
        end else if (w_access) begin
            resp_err   <= !w_in_range;
            resp_rdata <= (w_in_range && !w_acc_wen) ? r_mem[w_idx] : '0;
        end
    end

endmodule

// File: tb/tb_sram_responder.sv
// Scoreboard bench for sram_responder: driver pushes model expectations, monitor checks responses.
module tb_sram_responder;

    localparam int unsigned     LAT   = 1;
    localparam logic [31:0]     BASE  = 32'h8000_0000;
    localparam longint unsigned WORDS = 1024;

    logic        clk = 1'b0;
    logic        rst = 1'b0;

    logic        req_valid, req_ready, req_wen, resp_valid, resp_ready, resp_err;
    logic [31:0] req_addr, req_wdata, resp_rdata;
    logic [3:0]  req_wmask;

    logic        req_valid0, req_ready0, req_wen0, resp_valid0, resp_ready0, resp_err0;
    logic [31:0] req_addr0, req_wdata0, resp_rdata0;
    logic [3:0]  req_wmask0;

    sram_responder #(.DEPTH_LOG2(10), .BASE_ADDR(BASE), .LATENCY(LAT)) u_dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
        .req_wen(req_wen), .req_wdata(req_wdata), .req_wmask(req_wmask),
        .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_rdata(resp_rdata), .resp_err(resp_err)
    );

    sram_responder #(.DEPTH_LOG2(10), .BASE_ADDR(BASE), .LATENCY(0)) u_dut0 (
        .clk(clk), .rst(rst),
        .req_valid(req_valid0), .req_ready(req_ready0), .req_addr(req_addr0),
        .req_wen(req_wen0), .req_wdata(req_wdata0), .req_wmask(req_wmask0),
        .resp_valid(resp_valid0), .resp_ready(resp_ready0),
        .resp_rdata(resp_rdata0), .resp_err(resp_err0)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0]     rdata;
        logic            err;
        longint unsigned due;
    } exp_t;

    int unsigned     checks   = 0;
    int unsigned     failures = 0;
    longint unsigned ncyc     = 0;
    exp_t            sb[$];
    logic [31:0]     mdl[int unsigned];
    bit              seen     = 1'b0;
    int unsigned     bp_mode  = 0;
    longint unsigned acc[$];

    always @(posedge clk) ncyc <= ncyc + 1;

    always @(posedge clk) begin
        #1;
        case (bp_mode)
            0:       resp_ready = 1'b1;
            1:       resp_ready = ($urandom_range(0, 2) != 0);
            default: resp_ready = 1'b0;
        endcase
    end

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: actual=%h required=%h", name, act, exp);
        end
    endfunction

    function automatic void timeout(input string name);
        checks++;
        failures++;
        $display("FAIL %s: actual=timeout required=event", name);
    endfunction

    // Reference: memory as a map of word index -> value, range by plain 64-bit arithmetic
    function automatic exp_t model(input logic [31:0] a, input logic w, input logic [31:0] d, input logic [3:0] m);
        exp_t            e;
        longint unsigned la  = 64'(a);
        longint unsigned lim = 64'(BASE) + 4 * WORDS;
        int unsigned     idx;
        logic [31:0]     word;
        e.due = 0;
        if (la < 64'(BASE) || la >= lim) begin
            e.rdata = '0;
            e.err   = 1'b1;
        end else begin
            idx   = int'((la - 64'(BASE)) / 4);
            e.err = 1'b0;
            word  = mdl.exists(idx) ? mdl[idx] : '0;
            if (w) begin
                for (int b = 0; b < 4; b++)
                    if (m[b]) word[8*b +: 8] = d[8*b +: 8];
                mdl[idx] = word;
                e.rdata  = '0;
            end else begin
                e.rdata = word;
            end
        end
        return e;
    endfunction

    task automatic do_req(input logic [31:0] a, input logic w, input logic [31:0] d, input logic [3:0] m);
        exp_t e;
        bit   got = 1'b0;
        @(posedge clk);
        #1;
        req_addr  = a;
        req_wen   = w;
        req_wdata = d;
        req_wmask = m;
        req_valid = 1'b1;
        for (int i = 0; i < 64 && !got; i++) begin
            @(negedge clk);
            if (req_ready) got = 1'b1;
        end
        if (got) begin
            e     = model(a, w, d, m);
            e.due = ncyc + LAT + 1;
            sb.push_back(e);
        end else begin
            timeout("req_accept");
        end
        @(posedge clk);
        #1;
        req_valid = 1'b0;
    endtask

    task automatic wait_drain();
        bit done = 1'b0;
        for (int i = 0; i < 200 && !done; i++) begin
            @(negedge clk);
            if (sb.size() == 0 && !resp_valid) done = 1'b1;
        end
        if (!done) timeout("drain");
    endtask

    always @(negedge clk) begin
        if (rst && resp_valid) begin
            if (sb.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_resp: actual resp_valid=1 required=0");
            end else begin
                if (!seen) begin
                    chk("latency", 32'(ncyc), 32'(sb[0].due));
                    seen = 1'b1;
                end
                chk("rdata", resp_rdata, sb[0].rdata);
                chk("err", 32'(resp_err), 32'(sb[0].err));
                chk("req_ready_in_resp", 32'(req_ready), 32'd0);
                if (resp_ready) begin
                    void'(sb.pop_front());
                    seen = 1'b0;
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: actual=running required=finished");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0]     a;
        int unsigned     idx;
        int unsigned     r;
        bit              got;
        longint unsigned k;
        logic [31:0]     oor[5];

        req_valid = 0; req_addr = '0; req_wen = 0; req_wdata = '0; req_wmask = '0;
        req_valid0 = 0; req_addr0 = '0; req_wen0 = 0; req_wdata0 = '0; req_wmask0 = '0;
        resp_ready = 1'b1; resp_ready0 = 1'b1;
        oor[0] = 32'h7FFF_FFFC; oor[1] = 32'h8000_1000; oor[2] = 32'h0000_0000;
        oor[3] = 32'hFFFF_FFFC; oor[4] = 32'h8000_1003;

        repeat (2) @(negedge clk);
        chk("rst_req_ready", 32'(req_ready), 32'd1);
        chk("rst_resp_valid", 32'(resp_valid), 32'd0);
        chk("rst_rdata", resp_rdata, 32'd0);
        chk("rst_err", 32'(resp_err), 32'd0);
        chk("rst_req_ready0", 32'(req_ready0), 32'd1);
        chk("rst_resp_valid0", 32'(resp_valid0), 32'd0);
        @(posedge clk);
        #1 rst = 1'b1;

        for (int unsigned j = 0; j < 20; j++) begin
            idx = (j < 16) ? j : 1004 + j;
            do_req(BASE + 32'(idx * 4), 1'b1, (j == 0) ? 32'hCAFE_F00D : $urandom, 4'hF);
        end

        do_req(32'h8000_0010, 1'b1, 32'hDEAD_BEEF, 4'hF);
        do_req(32'h8000_0010, 1'b0, '0, 4'h0);
        do_req(32'h8000_0010, 1'b1, 32'h0000_5500, 4'b0010);
        do_req(32'h8000_0010, 1'b0, '0, 4'h0);
        do_req(32'h7FFF_FFFC, 1'b0, '0, 4'h0);
        do_req(32'h8000_1000, 1'b1, 32'h1111_2222, 4'hF);
        do_req(32'h8000_0000, 1'b0, '0, 4'h0);
        do_req(32'h8000_0FFC, 1'b0, '0, 4'h0);
        do_req(32'h8000_0014, 1'b1, 32'h7777_7777, 4'h0);
        do_req(32'h8000_0014, 1'b0, '0, 4'h0);
        wait_drain();
        chk("raw_dead55ef_model", mdl[4], 32'hDEAD_55EF);

        // Backpressure with an ignored request pulse during RESP
        bp_mode = 2;
        do_req(32'h8000_0004, 1'b0, '0, 4'h0);
        got = 1'b0;
        for (int i = 0; i < 10 && !got; i++) begin
            @(negedge clk);
            if (resp_valid) got = 1'b1;
        end
        if (!got) timeout("bp_resp");
        @(posedge clk);
        #1;
        req_addr = 32'h8000_0004; req_wen = 1'b1; req_wdata = 32'h0; req_wmask = 4'hF;
        req_valid = 1'b1;
        @(posedge clk);
        #1 req_valid = 1'b0;
        repeat (3) begin
            @(negedge clk);
            chk("bp_hold", 32'(resp_valid), 32'd1);
        end
        bp_mode = 0;
        got = 1'b0;
        for (int i = 0; i < 10 && !got; i++) begin
            @(negedge clk);
            if (!resp_valid) got = 1'b1;
        end
        if (!got) timeout("bp_release");
        chk("bp_req_ready_after", 32'(req_ready), 32'd1);
        do_req(32'h8000_0004, 1'b0, '0, 4'h0);
        wait_drain();

        // Reset while the write sits in WAIT: write must never land
        do_req(32'h8000_0000, 1'b0, '0, 4'h0);
        wait_drain();
        @(posedge clk);
        #1;
        req_addr = 32'h8000_0000; req_wen = 1'b1; req_wdata = 32'h1234_5678; req_wmask = 4'hF;
        req_valid = 1'b1;
        @(negedge clk);
        chk("rw_accept_ready", 32'(req_ready), 32'd1);
        @(posedge clk);
        #1 req_valid = 1'b0;
        chk("rw_in_wait", 32'(req_ready), 32'd0);
        rst = 1'b0;
        #1;
        chk("rw_rst_rdata", resp_rdata, 32'd0);
        chk("rw_rst_err", 32'(resp_err), 32'd0);
        chk("rw_rst_valid", 32'(resp_valid), 32'd0);
        chk("rw_rst_ready", 32'(req_ready), 32'd1);
        @(posedge clk);
        @(posedge clk);
        #1 rst = 1'b1;
        do_req(32'h8000_0000, 1'b0, '0, 4'h0);
        wait_drain();

        bp_mode = 1;
        for (int n = 0; n < 200; n++) begin
            r = $urandom_range(0, 9);
            if (r < 8) begin
                idx = $urandom_range(0, 19);
                if (idx >= 16) idx = idx + 1004;
                a = BASE + 32'(idx * 4) + 32'($urandom_range(0, 3));
            end else begin
                a = oor[$urandom_range(0, 4)];
            end
            do_req(a, 1'($urandom_range(0, 1)), $urandom, 4'($urandom_range(0, 15)));
        end
        wait_drain();
        bp_mode = 0;

        // Zero-latency instance
        @(posedge clk);
        #1;
        req_addr0 = 32'h8000_0004; req_wen0 = 1'b1; req_wdata0 = 32'hA5A5_5A5A; req_wmask0 = 4'hF;
        req_valid0 = 1'b1;
        got = 1'b0;
        for (int i = 0; i < 8 && !got; i++) begin
            @(negedge clk);
            if (req_ready0) got = 1'b1;
        end
        if (!got) timeout("l0_write_accept");
        @(posedge clk);
        #1 req_valid0 = 1'b0;
        @(negedge clk);
        chk("l0_wr_valid", 32'(resp_valid0), 32'd1);
        chk("l0_wr_rdata", resp_rdata0, 32'd0);
        chk("l0_wr_err", 32'(resp_err0), 32'd0);

        @(posedge clk);
        #1;
        req_wen0 = 1'b0;
        req_valid0 = 1'b1;
        got = 1'b0;
        k = 0;
        for (int i = 0; i < 8 && !got; i++) begin
            @(negedge clk);
            if (req_ready0) begin
                got = 1'b1;
                k = ncyc;
            end
        end
        if (!got) timeout("l0_read_accept");
        @(posedge clk);
        #1 req_valid0 = 1'b0;
        @(negedge clk);
        chk("l0_rd_latency", 32'(ncyc - k), 32'd1);
        chk("l0_rd_valid", 32'(resp_valid0), 32'd1);
        chk("l0_rd_rdata", resp_rdata0, 32'hA5A5_5A5A);
        @(negedge clk);
        chk("l0_rd_one_cycle", 32'(resp_valid0), 32'd0);

        @(posedge clk);
        #1 req_valid0 = 1'b1;
        repeat (8) begin
            @(negedge clk);
            if (req_ready0) acc.push_back(ncyc);
        end
        @(posedge clk);
        #1 req_valid0 = 1'b0;
        chk("l0_b2b_count", 32'(acc.size()), 32'd4);
        for (int i = 1; i < acc.size(); i++)
            chk("l0_b2b_spacing", 32'(acc[i] - acc[i-1]), 32'd2);
        repeat (2) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
